// File: rtl/fetch_decode_stage.sv
// Fetch PC register and IF/ID pipeline register for the pipelined ARM core.
// Also derives register-file read addresses and the R15 (PC+8) value for decode.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall_f,
  input  logic        stall_d,
  input  logic        flush_d,
  input  logic        branch_taken_e,
  input  logic [31:0] branch_target_e,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic [1:0]  reg_src,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        valid_d,
  output logic [3:0]  ra1_d,
  output logic [3:0]  ra2_d,
  output logic [31:0] r15_d
);

  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  logic [31:0] r_pc_f;
  logic [31:0] r_instr_d;
  logic [31:0] r_pc_d;
  logic        r_valid_d;
  logic [31:0] w_pc_next;

  // Next fetch address: a taken branch outranks a fetch stall.
  always_comb begin
    w_pc_next = r_pc_f + 32'd4;
    if (branch_taken_e) begin
      w_pc_next = {branch_target_e[31:2], 2'b00};
    end else if (stall_f) begin
      w_pc_next = r_pc_f;
    end else begin
      w_pc_next = r_pc_f + 32'd4;
    end
  end

  // PC_F register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc_f <= RESET_PC_ALIGNED;
    end else begin
      r_pc_f <= w_pc_next;
    end
  end

  // IF/ID register; squashing outranks holding so a redirect never leaves a stale word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_instr_d <= 32'h0000_0000;
      r_pc_d    <= 32'h0000_0000;
      r_valid_d <= 1'b0;
    end else if (flush_d || branch_taken_e) begin
      r_instr_d <= 32'h0000_0000;
      r_pc_d    <= 32'h0000_0000;
      r_valid_d <= 1'b0;
    end else if (stall_d) begin
      r_instr_d <= r_instr_d;
      r_pc_d    <= r_pc_d;
      r_valid_d <= r_valid_d;
    end else begin
      r_instr_d <= imem_rdata;
      r_pc_d    <= r_pc_f;
      r_valid_d <= 1'b1;
    end
  end

  // Register-file read ports must see these in the same cycle as instr_d.
  always_comb begin
    if (reg_src[0]) begin
      ra1_d = 4'hF;
    end else begin
      ra1_d = r_instr_d[19:16];
    end
    if (reg_src[1]) begin
      ra2_d = r_instr_d[15:12];
    end else begin
      ra2_d = r_instr_d[3:0];
    end
  end

  assign r15_d     = r_pc_d + 32'd8;
  assign imem_addr = r_pc_f;
  assign instr_d   = r_instr_d;
  assign pc_d      = r_pc_d;
  assign valid_d   = r_valid_d;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Scoreboard bench for fetch_decode_stage: driver pushes predicted outputs,
// monitor pops and compares after every rising edge.
module tb_fetch_decode_stage;

  logic        clk;
  logic        reset_n;
  logic        stall_f;
  logic        stall_d;
  logic        flush_d;
  logic        branch_taken_e;
  logic [31:0] branch_target_e;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [1:0]  reg_src;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic        valid_d;
  logic [3:0]  ra1_d;
  logic [3:0]  ra2_d;
  logic [31:0] r15_d;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pcd;
    logic        valid;
    logic [3:0]  ra1;
    logic [3:0]  ra2;
    logic [31:0] r15;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  bit   go    = 1'b0;

  // reference model state
  logic [31:0] m_pc;
  logic [31:0] m_instr;
  logic [31:0] m_pcd;
  logic        m_valid;

  fetch_decode_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset_n(reset_n), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .branch_taken_e(branch_taken_e),
    .branch_target_e(branch_target_e), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .reg_src(reg_src), .instr_d(instr_d),
    .pc_d(pc_d), .valid_d(valid_d), .ra1_d(ra1_d), .ra2_d(ra2_d), .r15_d(r15_d)
  );

  function automatic logic [31:0] imem(input logic [31:0] a);
    if (a == 32'h0000_0200) return 32'hE591_2003;
    return a + 32'hE000_0000;
  endfunction

  assign imem_rdata = imem(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0000_0000; m_instr = 32'h0; m_pcd = 32'h0; m_valid = 1'b0;
  endtask

  // One cycle of stimulus plus the prediction of outputs after the next rising edge.
  task automatic step(input logic rst, input logic sf, input logic sd, input logic fl,
                      input logic br, input logic [31:0] tgt, input logic [1:0] rs);
    exp_t e;
    @(negedge clk);
    reset_n = rst; stall_f = sf; stall_d = sd; flush_d = fl;
    branch_taken_e = br; branch_target_e = tgt; reg_src = rs;
    if (!rst) begin
      model_reset();
    end else begin
      if (fl || br) begin
        m_instr = 32'h0; m_pcd = 32'h0; m_valid = 1'b0;
      end else if (!sd) begin
        m_instr = imem(m_pc); m_pcd = m_pc; m_valid = 1'b1;
      end
      if (br)       m_pc = tgt & 32'hFFFF_FFFC;
      else if (!sf) m_pc = m_pc + 32'd4;
    end
    e.addr  = m_pc;
    e.instr = m_instr;
    e.pcd   = m_pcd;
    e.valid = m_valid;
    e.ra1   = rs[0] ? 4'hF : m_instr[19:16];
    e.ra2   = rs[1] ? m_instr[15:12] : m_instr[3:0];
    e.r15   = m_pcd + 32'd8;
    q.push_back(e);
    go = 1'b1;
  endtask

  task automatic chk_reset_now();
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pcd",   pc_d, 32'h0);
    chk("rst_valid", {31'd0, valid_d}, 32'd0);
    chk("rst_r15",   r15_d, 32'd8);
  endtask

  // Monitor: compare DUT outputs against the oldest prediction after each edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (go) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 32'd0, 32'd1);
        end else begin
          e = q.pop_front();
          chk("imem_addr", imem_addr, e.addr);
          chk("instr_d", instr_d, e.instr);
          chk("pc_d", pc_d, e.pcd);
          chk("valid_d", {31'd0, valid_d}, {31'd0, e.valid});
          chk("ra1_d", {28'd0, ra1_d}, {28'd0, e.ra1});
          chk("ra2_d", {28'd0, ra2_d}, {28'd0, e.ra2});
          chk("r15_d", r15_d, e.r15);
        end
      end
    end
  end

  initial begin
    logic sf, sd;
    reset_n = 1'b0; stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0;
    branch_taken_e = 1'b0; branch_target_e = 32'h0; reg_src = 2'b00;
    model_reset();
    #2;
    chk_reset_now();

    // reset, then straight-line fetch
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    // full stall then resume
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b00);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    // branch with fetch stall in the same cycle
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    // flush beats stall_d
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 2'b00);
    // decode of E591_2003 under each reg_src
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0201, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b01);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b10);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 2'b11);
    // PC wrap at top of address space
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    // asynchronous reset between edges
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    #2;
    chk_reset_now();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 2'b00);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      sf = ($urandom % 5) == 0;
      sd = sf ? 1'($urandom % 2) : (($urandom % 20) == 0);
      step(($urandom % 60) != 0, sf, sd, ($urandom % 8) == 0, ($urandom % 8) == 0,
           $urandom, 2'($urandom % 4));
    end

    for (int i = 0; i < 4 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) chk("sb_drain", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
